// File: rtl/seq_cmp_pkg.sv
// ============================================================================
// Module   : seq_cmp_pkg
// Purpose  : Shared state encoding, result codes and width helper for
//            seq_comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CMP_LT = 2'd0;
    localparam logic [1:0] CMP_EQ = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_cmp.sv
// ============================================================================
// Module   : digit_cmp
// Purpose  : Combinational DIGIT-bit unsigned magnitude compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    output logic             dgt,
    output logic             dlt
);

    assign dgt = (da > db);
    assign dlt = (da < db);

endmodule

`default_nettype wire

// File: rtl/seq_comparator.sv
// ============================================================================
// Module   : seq_comparator
// Purpose  : Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock,
//            unsigned or two's-complement. Optional macro
//            SEQ_CMP_EARLY_EXIT_EN ends RUN at the first differing digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_decided;
    logic [1:0]       r_code;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;

    logic             w_dgt;
    logic             w_dlt;
    logic [1:0]       w_code;
    logic             w_finish;
    logic             w_accept;
    logic [WIDTH-1:0] w_msb_flip;

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .da  (r_sa[WIDTH-1 -: DIGIT]),
        .db  (r_sb[WIDTH-1 -: DIGIT]),
        .dgt (w_dgt),
        .dlt (w_dlt)
    );

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign w_msb_flip = {is_signed, {(WIDTH-1){1'b0}}};

    assign w_accept = start && (r_state != RUN);

    always_comb begin
        w_code = CMP_EQ;
        if (r_decided) begin
            w_code = r_code;
        end else if (w_dgt) begin
            w_code = CMP_GT;
        end else if (w_dlt) begin
            w_code = CMP_LT;
        end
    end

    always_comb begin
        w_finish = 1'b0;
        if (r_state == RUN) begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
            w_finish = (r_cnt == C_LAST) || (w_dgt || w_dlt);
`else
            w_finish = (r_cnt == C_LAST);
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_finish) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sa      <= '0;
            r_sb      <= '0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_code    <= CMP_EQ;
            r_gt      <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sa      <= a ^ w_msb_flip;
                r_sb      <= b ^ w_msb_flip;
                r_cnt     <= '0;
                r_decided <= 1'b0;
                r_code    <= CMP_EQ;
            end else if (r_state == RUN) begin
                r_sa      <= r_sa << DIGIT;
                r_sb      <= r_sb << DIGIT;
                r_cnt     <= r_cnt + CNT_W'(1);
                r_decided <= r_decided || w_dgt || w_dlt;
                r_code    <= w_code;
            end
            // Result flags move only on the edge that enters DONE.
            if (w_finish) begin
                r_gt <= (w_code == CMP_GT);
                r_eq <= (w_code == CMP_EQ);
                r_lt <= (w_code == CMP_LT);
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign gt   = r_gt;
    assign eq   = r_eq;
    assign lt   = r_lt;

endmodule

`default_nettype wire
